// File: rtl/handshake_fifo_pkg.sv
// Shared helpers for the handshake burst FIFO: width derivation, pointer
// compare functions and the per-cycle operation encoding.
package handshake_fifo_pkg;

  // Widest pointer the compare helpers accept; callers zero-extend into it.
  localparam int PTR_BUS_W = 32;

  typedef logic [PTR_BUS_W-1:0] ptr_bus_t;

  // Encoded as {pop, push} so the handshake bits cast straight into it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic logic ptrs_empty(input ptr_bus_t rd_ptr, input ptr_bus_t wr_ptr);
    return rd_ptr == wr_ptr;
  endfunction

  // Full when the index bits match and only the wrap bit differs.
  function automatic logic ptrs_full(input ptr_bus_t rd_ptr, input ptr_bus_t wr_ptr,
                                     input int idx_w);
    return (rd_ptr ^ wr_ptr) == (ptr_bus_t'(1) << idx_w);
  endfunction

endpackage

// File: rtl/fifo_regfile_2p.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// asynchronous read port.
module fifo_regfile_2p
  import handshake_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage carries no reset; pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_burst_fifo.sv
// Burst-absorbing first-word-fall-through FIFO ahead of the CDC handshake
// synchronizer. Define HANDSHAKE_BURST_FIFO_WATERMARK_EN for peak_level tracking.
module handshake_burst_fifo
  import handshake_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   peak_level,
  input  logic                     peak_clr
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] level_q,  level_d;
  logic             almost_full_q, almost_full_d;

  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  fifo_op_e op;

  // Flags come from registered pointers only, so in_ready never depends on out_ready.
  assign empty = ptrs_empty(ptr_bus_t'(rd_ptr_q), ptr_bus_t'(wr_ptr_q));
  assign full  = ptrs_full(ptr_bus_t'(rd_ptr_q), ptr_bus_t'(wr_ptr_q), IDX_W);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign op        = fifo_op_e'({pop, push});

  // NOTE: every always_comb output gets its hold value first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    unique case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + ONE;
        level_d  = level_q + ONE;
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + ONE;
        level_d  = level_q - ONE;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + ONE;
        rd_ptr_d = rd_ptr_q + ONE;
      end
      default: ;
    endcase
    almost_full_d = (level_d >= AF_LEVEL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign level       = level_q;
  assign almost_full = almost_full_q;

  fifo_regfile_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[IDX_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[IDX_W-1:0]),
    .rdata (out_data)
  );

`ifdef HANDSHAKE_BURST_FIFO_WATERMARK_EN
  logic [PTR_W-1:0] peak_level_q, peak_level_d;

  // A clear reloads from the next level, so the clear cycle's occupancy is kept.
  always_comb begin
    peak_level_d = peak_level_q;
    if (peak_clr) begin
      peak_level_d = level_d;
    end else if (level_d > peak_level_q) begin
      peak_level_d = level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) peak_level_q <= '0;
    else     peak_level_q <= peak_level_d;
  end

  assign peak_level = peak_level_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_level      = '0;
`endif

endmodule
